// File: rtl/mul_s8s8_acc_stream_pkg.sv
// Shared constants, result layout and signed add helper for the
// mul_s8s8_acc_stream product accumulator.
`default_nettype none

package mul_s8s8_acc_stream_pkg;

   localparam int MUL_P3_LATENCY = 3;
   localparam int RES_DATA_W     = 16;
   localparam int RES_COUNT_W    = 8;

   typedef struct packed {
      logic [RES_DATA_W-1:0]  data;
      logic [RES_COUNT_W-1:0] count;
      logic                   ovf;
   } res_t;

   typedef enum logic [0:0] {
      ADD_WRAP = 1'b0,
      ADD_SAT  = 1'b1
   } add_mode_e;

   // Returns {overflow, result}; operands arrive sign-extended to 64 bits
   // and the result is clamped or wrapped back into a width-bit signed range.
   function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                           input logic signed [63:0] b,
                                           input int unsigned        width,
                                           input add_mode_e          mode);
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] res;
      logic               ovf;
      sum = a + b;
      hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      ovf = (sum > hi) || (sum < lo);
      res = sum;
      if (ovf) begin
         if (mode == ADD_SAT) begin
            res = (sum > hi) ? hi : lo;
         end else begin
            res = (sum <<< (64 - width)) >>> (64 - width);
         end
      end
      return {ovf, res};
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_s8s8_acc_stream_if.sv
// Issue, product and result-stream signals between the accumulator block
// and its issuer / multiplier / consumer.
`default_nettype none

interface mul_s8s8_acc_stream_if
   import mul_s8s8_acc_stream_pkg::*;
#(
   parameter int ACC_WIDTH = RES_DATA_W,
   parameter int CNT_WIDTH = RES_COUNT_W
);
   logic                        s_valid;
   logic                        s_last;
   logic                        s_ready;
   logic                        ce;
   logic signed [7:0]           p;
   logic                        m_valid;
   logic                        m_ready;
   logic signed [ACC_WIDTH-1:0] m_data;
   logic [CNT_WIDTH-1:0]        m_count;
   logic                        m_ovf;

   modport slave (
      input  s_valid, s_last, p, m_ready,
      output s_ready, ce, m_valid, m_data, m_count, m_ovf
   );

   modport master (
      output s_valid, s_last, p, m_ready,
      input  s_ready, ce, m_valid, m_data, m_count, m_ovf
   );
endinterface

`default_nettype wire

// File: rtl/mul_s8s8_acc_stream_fifo.sv
// Generic synchronous FIFO with registered storage and synchronous
// active-low reset; head entry is read straight from storage.
`default_nettype none

module stream_fifo_sync #(
   parameter int WIDTH      = 25,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             wr_en;
   logic             rd_en;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
            wr_q                <= wr_q + (AW + 1)'(1);
         end
         if (rd_en) begin
            rd_q <= rd_q + (AW + 1)'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_s8s8_acc_stream.sv
// Per-frame accumulator for the 3-stage signed 8x8 low-byte multiplier;
// drives the multiplier CE so a full result FIFO stalls the whole pipe.
`default_nettype none

module mul_s8s8_acc_stream
   import mul_s8s8_acc_stream_pkg::*;
#(
   parameter int LATENCY    = MUL_P3_LATENCY,
   parameter int ACC_WIDTH  = RES_DATA_W,
   parameter int CNT_WIDTH  = RES_COUNT_W,
   parameter bit SATURATE   = 1'b1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   mul_s8s8_acc_stream_if.slave  bus
);
   localparam int        RW   = ACC_WIDTH + CNT_WIDTH + 1;
   localparam add_mode_e MODE = SATURATE ? ADD_SAT : ADD_WRAP;

   logic [LATENCY-1:0]          vld_q;
   logic [LATENCY-1:0]          vld_d;
   logic [LATENCY-1:0]          lst_q;
   logic [LATENCY-1:0]          lst_d;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic [CNT_WIDTH-1:0]        cnt_q;
   logic [CNT_WIDTH-1:0]        cnt_d;
   logic                        ovf_q;
   logic                        ovf_d;

   logic                        ce;
   logic                        take;
   logic                        push;
   logic                        pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [RW-1:0]               push_data;
   logic [RW-1:0]               head;
   logic [64:0]                 add_res;
   logic                        add_unused;
   logic signed [ACC_WIDTH-1:0] sum;
   logic                        sum_ovf;
   logic [CNT_WIDTH-1:0]        cnt_inc;

   // Any space in the FIFO, or a pop this cycle, lets the entire pipe advance.
   assign ce          = !fifo_full || bus.m_ready;
   assign bus.ce      = ce;
   assign bus.s_ready = ce;

   generate
      if (LATENCY == 1) begin : g_pipe_single
         assign vld_d = bus.s_valid;
         assign lst_d = bus.s_valid & bus.s_last;
      end else begin : g_pipe_shift
         assign vld_d = {vld_q[LATENCY-2:0], bus.s_valid};
         assign lst_d = {lst_q[LATENCY-2:0], bus.s_valid & bus.s_last};
      end
   endgenerate

   assign take       = ce && vld_q[LATENCY-1];
   assign add_res    = sat_add(64'(acc_q), 64'(bus.p), ACC_WIDTH, MODE);
   assign sum        = add_res[ACC_WIDTH-1:0];
   assign sum_ovf    = add_res[64];
   assign add_unused = ^add_res[63:ACC_WIDTH];
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      push_data = {sum, cnt_inc, ovf_q | sum_ovf};
      if (take) begin
         if (lst_q[LATENCY-1]) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sum_ovf;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_q <= '0;
         lst_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (ce) begin
         vld_q <= vld_d;
         lst_q <= lst_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign pop = !fifo_empty && bus.m_ready;

   stream_fifo_sync #(
      .WIDTH      (RW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.m_valid = !fifo_empty;
   assign bus.m_data  = head[RW-1 -: ACC_WIDTH];
   assign bus.m_count = head[CNT_WIDTH:1];
   assign bus.m_ovf   = head[0];

endmodule

`default_nettype wire

// File: tb/tb_mul_s8s8_acc_stream.sv
// Scoreboard bench for mul_s8s8_acc_stream with a behavioural 3-stage
// multiplier that has no reset.
`default_nettype none

module tb_mul_s8s8_acc_stream;
   import mul_s8s8_acc_stream_pkg::*;

   logic              clk;
   logic              rst_n;
   logic signed [7:0] a;
   logic signed [7:0] b;
   logic signed [7:0] ma_q, mb_q, mp1_q, mp2_q;

   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;
   res_t last_res;
   res_t exp_q [$];
   int   acc_m;
   int   cnt_m;
   bit   ovf_m;

   mul_s8s8_acc_stream_if bus ();

   mul_s8s8_acc_stream dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ce) begin
         ma_q  <= a;
         mb_q  <= b;
         mp1_q <= ma_q * mb_q;
         mp2_q <= mp1_q;
      end
   end
   assign bus.p = mp2_q;

   function automatic res_t mk(input int d, input int c, input bit o);
      res_t r;
      r.data  = 16'(d);
      r.count = 8'(c);
      r.ovf   = o;
      return r;
   endfunction

   // Reference model: updated at issue, compared at pop.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_m = 0;
         cnt_m = 0;
         ovf_m = 1'b0;
         exp_q.delete();
      end else begin
         if (bus.m_valid && bus.m_ready) begin
            res_t got;
            got = {bus.m_data, bus.m_count, bus.m_ovf};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected got=%h exp=none", got);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL sb_result got data=%0d cnt=%0d ovf=%0b exp data=%0d cnt=%0d ovf=%0b",
                           $signed(got.data), got.count, got.ovf, $signed(e.data), e.count, e.ovf);
               end
            end
            pops++;
            last_res = got;
         end
         if (bus.s_valid && bus.s_ready) begin
            int pv;
            pv = int'(a) * int'(b);
            pv = ((pv % 256) + 256) % 256;
            if (pv > 127) pv -= 256;
            acc_m += pv;
            if (acc_m > 32767) begin acc_m = 32767; ovf_m = 1'b1; end
            if (acc_m < -32768) begin acc_m = -32768; ovf_m = 1'b1; end
            if (cnt_m < 255) cnt_m++;
            if (bus.s_last) begin
               exp_q.push_back(mk(acc_m, cnt_m, ovf_m));
               acc_m = 0;
               cnt_m = 0;
               ovf_m = 1'b0;
            end
         end
      end
   end

   task automatic issue(input int av, input int bv, input bit last);
      int n;
      a           = 8'(av);
      b           = 8'(bv);
      bus.s_last  = last;
      bus.s_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.s_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!bus.s_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout got=s_ready0 exp=s_ready1");
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      repeat (6) @(negedge clk);
      n = 0;
      while ((exp_q.size() != 0 || bus.m_valid) && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || bus.m_valid) begin
         failures++;
         $display("FAIL drain_timeout got=pending%0d exp=0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", bus.m_valid); end
      if (bus.m_data !== 16'd0) begin failures++; $display("FAIL reset_m_data got=%0d exp=0", bus.m_data); end
      if (bus.m_count !== 8'd0) begin failures++; $display("FAIL reset_m_count got=%0d exp=0", bus.m_count); end
      if (bus.m_ovf !== 1'b0) begin failures++; $display("FAIL reset_m_ovf got=%0b exp=0", bus.m_ovf); end
      if (bus.ce !== 1'b1) begin failures++; $display("FAIL reset_ce got=%0b exp=1", bus.ce); end
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      bus.m_ready = 1'b1;
   endtask

   task automatic test_frame4();
      int n;
      for (int i = 0; i < 4; i++) issue(3, 2, i == 3);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.m_valid && n < 10);
      checks++;
      if (n !== 4) begin failures++; $display("FAIL frame4_latency got=%0d exp=4", n); end
      wait_drain();
      checks++;
      if (last_res !== mk(24, 4, 0)) begin
         failures++;
         $display("FAIL frame4_result got=%h exp=%h", last_res, mk(24, 4, 0));
      end
   endtask

   task automatic test_signed();
      issue(-128, -1, 1'b0);
      issue(16, 16, 1'b1);
      wait_drain();
      checks++;
      if (last_res !== mk(-128, 2, 0)) begin
         failures++;
         $display("FAIL signed_result got=%h exp=%h", last_res, mk(-128, 2, 0));
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) issue(127, 1, i == 299);
      wait_drain();
      checks++;
      if (last_res !== mk(32767, 255, 1)) begin
         failures++;
         $display("FAIL sat_result got=%h exp=%h", last_res, mk(32767, 255, 1));
      end
      issue(1, 1, 1'b1);
      wait_drain();
      checks++;
      if (last_res !== mk(1, 1, 0)) begin
         failures++;
         $display("FAIL sat_next_frame got=%h exp=%h", last_res, mk(1, 1, 0));
      end
   endtask

   task automatic test_backpressure();
      int p0;
      p0 = pops;
      bus.m_ready = 1'b0;
      fork
         begin
            for (int k = 1; k <= 5; k++) issue(k, 1, 1'b1);
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (bus.ce && n < 30) begin
               n++;
               @(negedge clk);
            end
            checks++;
            if (bus.ce !== 1'b0 || !bus.m_valid || bus.m_data !== 16'sd1) begin
               failures++;
               $display("FAIL bp_ce_drop got=ce%0b valid%0b data%0d exp=ce0 valid1 data1",
                        bus.ce, bus.m_valid, bus.m_data);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (bus.ce !== 1'b0 || bus.m_data !== 16'sd1) begin
               failures++;
               $display("FAIL bp_hold got=ce%0b data%0d exp=ce0 data1", bus.ce, bus.m_data);
            end
            @(posedge clk);
            #1;
            bus.m_ready = 1'b1;
         end
      join
      wait_drain();
      checks++;
      if (pops - p0 !== 5 || last_res !== mk(5, 1, 0)) begin
         failures++;
         $display("FAIL bp_results got=%0d/%h exp=5/%h", pops - p0, last_res, mk(5, 1, 0));
      end
   endtask

   task automatic test_reset_midframe();
      int p0;
      issue(5, 5, 1'b0);
      issue(5, 5, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      p0 = pops;
      issue(1, 1, 1'b1);
      wait_drain();
      checks++;
      if (pops - p0 !== 1 || last_res !== mk(1, 1, 0)) begin
         failures++;
         $display("FAIL midreset_result got=%0d/%h exp=1/%h", pops - p0, last_res, mk(1, 1, 0));
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pops;
      bus.m_ready = 1'b0;
      fork
         begin
            for (int k = 1; k <= 12; k++) issue(k, 2, 1'b1);
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (bus.ce && n < 30) begin
               n++;
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            bus.m_ready = 1'b1;
            for (int c = 0; c < 8; c++) begin
               @(negedge clk);
               checks++;
               if (bus.ce !== 1'b1 || bus.m_valid !== 1'b1) begin
                  failures++;
                  $display("FAIL b2b_cycle%0d got=ce%0b valid%0b exp=ce1 valid1", c, bus.ce, bus.m_valid);
               end
            end
         end
      join
      wait_drain();
      checks++;
      if (pops - p0 !== 12) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=12", pops - p0);
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      a           = '0;
      b           = '0;
      rst_n       = 1'b0;
      test_reset();
      test_frame4();
      test_signed();
      test_saturate();
      test_backpressure();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
